// File: rtl/chunked_add_sub_pkg.sv
// Shared ALU definitions: FSM state encoding and add/sub op encoding.
// Imported by the ALU datapath blocks.
package chunked_add_sub_pkg;

   localparam logic ST_IDLE = 1'b0;
   localparam logic ST_RUN  = 1'b1;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/chunk_adder.sv
// Combinational N-bit adder slice with carry in/out.
// One instance is reused each cycle by the multi-cycle datapath.
module chunk_adder #(
   parameter int N = 2
) (
   input  logic [N-1:0] x,
   input  logic [N-1:0] y,
   input  logic         cin,
   output logic [N-1:0] s,
   output logic         cout
);

   logic [N:0] total;

   always_comb begin
      total = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, cin};
      s     = total[N-1:0];
      cout  = total[N];
   end

endmodule

// File: rtl/chunked_add_sub.sv
// Multi-cycle add/subtract: CHUNK bits per clock, LSB chunk first,
// with a registered ripple carry and start/busy/done handshake.
module chunked_add_sub #(
   parameter int WIDTH = 8,
   parameter int CHUNK = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             ovf,
   output logic             zero
);

   import chunked_add_sub_pkg::*;

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int CW     = $clog2(NCHUNK + 1);

   if (WIDTH < 1 || CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
      $error("chunked_add_sub: CHUNK must divide WIDTH");
   end

   logic             state_q, state_d;
   logic [WIDTH-1:0] opa_q, opa_d;
   logic [WIDTH-1:0] opb_q, opb_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic             carry_q, carry_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             a_msb_q, a_msb_d;
   logic             b_msb_q, b_msb_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             c_out_q, c_out_d;
   logic             ovf_q, ovf_d;
   logic             zero_q, zero_d;
   logic             done_q, done_d;

   logic [CHUNK-1:0] ch_s;
   logic             ch_cout;
   logic             accept;
   logic             running;
   logic             last;
   logic [WIDTH-1:0] res_next;
   logic [WIDTH-1:0] b_eff;

   chunk_adder #(
      .N(CHUNK)
   ) u_chunk (
      .x   (opa_q[CHUNK-1:0]),
      .y   (opb_q[CHUNK-1:0]),
      .cin (carry_q),
      .s   (ch_s),
      .cout(ch_cout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      running = (state_q == ST_RUN);
      last    = running && (cnt_q == CW'(NCHUNK - 1));
      accept  = (state_q == ST_IDLE) && start;
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (last)  state_d = ST_IDLE;
         default:            state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      busy  = (state_q == ST_RUN);
      done  = done_q;
      sum   = sum_q;
      c_out = c_out_q;
      ovf   = ovf_q;
      zero  = zero_q;
   end

   // New chunk enters at the top; after NCHUNK shifts it is aligned.
   always_comb begin
      b_eff    = (sub == OP_SUB) ? ~b : b;
      res_next = WIDTH'({ch_s, res_q} >> CHUNK);
      opa_d    = opa_q;
      opb_d    = opb_q;
      res_d    = res_q;
      carry_d  = carry_q;
      cnt_d    = cnt_q;
      a_msb_d  = a_msb_q;
      b_msb_d  = b_msb_q;
      sum_d    = sum_q;
      c_out_d  = c_out_q;
      ovf_d    = ovf_q;
      zero_d   = zero_q;
      done_d   = 1'b0;
      if (accept) begin
         opa_d   = a;
         opb_d   = b_eff;
         res_d   = '0;
         carry_d = sub;
         cnt_d   = '0;
         a_msb_d = a[WIDTH-1];
         b_msb_d = b_eff[WIDTH-1];
      end else if (running) begin
         opa_d   = opa_q >> CHUNK;
         opb_d   = opb_q >> CHUNK;
         res_d   = res_next;
         carry_d = ch_cout;
         cnt_d   = cnt_q + CW'(1);
         if (last) begin
            sum_d   = res_next;
            c_out_d = ch_cout;
            ovf_d   = (a_msb_q == b_msb_q)
                   && (res_next[WIDTH-1] != a_msb_q);
            zero_d  = (res_next == '0);
            done_d  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opa_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         a_msb_q <= a_msb_d;
         b_msb_q <= b_msb_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_chunked_add_sub.sv
// Directed bench for chunked_add_sub at CHUNK=2, 8 and 1 (WIDTH=8).
// Expected values are hand-computed constants.
module tb_chunked_add_sub;

   logic       clk;
   logic       rst;
   logic       sub;
   logic [7:0] a;
   logic [7:0] b;
   logic       start_w [3];
   logic       busy_w  [3];
   logic       done_w  [3];
   logic [7:0] sum_w   [3];
   logic       c_out_w [3];
   logic       ovf_w   [3];
   logic       zero_w  [3];

   int errors;
   int checks;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int CH = (g == 0) ? 2 : ((g == 1) ? 8 : 1);
      chunked_add_sub #(
         .WIDTH(8),
         .CHUNK(CH)
      ) u_dut (
         .clk  (clk),
         .rst  (rst),
         .start(start_w[g]),
         .sub  (sub),
         .a    (a),
         .b    (b),
         .busy (busy_w[g]),
         .done (done_w[g]),
         .sum  (sum_w[g]),
         .c_out(c_out_w[g]),
         .ovf  (ovf_w[g]),
         .zero (zero_w[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int nch(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 1 : 8);
   endfunction

   task automatic chk_outs(input int d, input string tag,
                           input int es, input int ec,
                           input int eo, input int ez);
      chk({tag, ".sum"},   int'(sum_w[d]),   es);
      chk({tag, ".c_out"}, int'(c_out_w[d]), ec);
      chk({tag, ".ovf"},   int'(ovf_w[d]),   eo);
      chk({tag, ".zero"},  int'(zero_w[d]),  ez);
   endtask

   // Issue an op, wait for done; returns positioned in the done cycle.
   task automatic do_op(input int d, input string tag,
                        input logic [7:0] av, input logic [7:0] bv,
                        input logic sv, input int es, input int ec,
                        input int eo, input int ez);
      int lat;
      int bcnt;
      a = av;
      b = bv;
      sub = sv;
      start_w[d] = 1'b1;
      tick();
      start_w[d] = 1'b0;
      a = 8'hA5;
      b = 8'h3C;
      sub = ~sv;
      lat = 0;
      bcnt = 0;
      while (!done_w[d] && lat < 30) begin
         if (busy_w[d]) bcnt++;
         tick();
         lat++;
      end
      chk({tag, ".latency"}, lat, nch(d));
      chk({tag, ".busy_cycles"}, bcnt, nch(d));
      chk({tag, ".busy_at_done"}, int'(busy_w[d]), 0);
      chk_outs(d, tag, es, ec, eo, ez);
   endtask

   initial begin
      int lat;
      errors = 0;
      checks = 0;
      rst = 1'b1;
      sub = 1'b0;
      a = '0;
      b = '0;
      for (int i = 0; i < 3; i++) start_w[i] = 1'b0;
      tick();
      tick();
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset%0d.busy", i), int'(busy_w[i]), 0);
         chk($sformatf("reset%0d.done", i), int'(done_w[i]), 0);
         chk_outs(i, $sformatf("reset%0d", i), 0, 0, 0, 0);
      end
      rst = 1'b0;
      tick();

      do_op(0, "add200_100", 8'd200, 8'd100, 1'b0, 44, 1, 0, 0);
      tick();
      chk("add200_100.done_pulse", int'(done_w[0]), 0);
      chk("add200_100.hold", int'(sum_w[0]), 44);
      do_op(0, "add127_1", 8'd127, 8'd1, 1'b0, 128, 0, 1, 0);
      tick();
      do_op(0, "sub5_5", 8'd5, 8'd5, 1'b1, 0, 1, 0, 1);
      tick();
      do_op(0, "sub3_5", 8'd3, 8'd5, 1'b1, 254, 0, 0, 0);
      tick();

      // start during busy is ignored; start in the done cycle is taken
      a = 8'd200;
      b = 8'd100;
      sub = 1'b0;
      start_w[0] = 1'b1;
      tick();
      start_w[0] = 1'b0;
      tick();
      a = 8'd1;
      b = 8'd1;
      start_w[0] = 1'b1;
      tick();
      start_w[0] = 1'b0;
      lat = 2;
      while (!done_w[0] && lat < 30) begin
         tick();
         lat++;
      end
      chk("ignored.latency", lat, 4);
      chk_outs(0, "ignored", 44, 1, 0, 0);
      do_op(0, "b2b1_1", 8'd1, 8'd1, 1'b0, 2, 0, 0, 0);
      tick();

      // reset in the 2nd RUN cycle aborts without done
      a = 8'd200;
      b = 8'd100;
      sub = 1'b0;
      start_w[0] = 1'b1;
      tick();
      start_w[0] = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("abort.busy", int'(busy_w[0]), 0);
      chk("abort.done", int'(done_w[0]), 0);
      chk_outs(0, "abort", 0, 0, 0, 0);
      lat = 0;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (done_w[0]) lat++;
      end
      chk("abort.no_done", lat, 0);
      do_op(0, "add10_20", 8'd10, 8'd20, 1'b0, 30, 0, 0, 0);
      tick();

      do_op(1, "c8_add200_100", 8'd200, 8'd100, 1'b0, 44, 1, 0, 0);
      tick();
      chk("c8.done_pulse", int'(done_w[1]), 0);
      do_op(2, "c1_add200_100", 8'd200, 8'd100, 1'b0, 44, 1, 0, 0);
      tick();
      chk("c1.done_pulse", int'(done_w[2]), 0);
      do_op(2, "c1_sub3_5", 8'd3, 8'd5, 1'b1, 254, 0, 0, 0);
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
